// File: rtl/toggle_rx.sv
// Receiver for a toggle-encoded event line: synchronizes, decodes each level change,
// timestamps the gap between events and holds the newest record until acknowledged.
module toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int TS_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             toggle_in,
  input  logic             ack,
  output logic             event_pulse,
  output logic             valid,
  output logic [TS_W-1:0]  interval,
  output logic [CNT_W-1:0] event_count,
  output logic             overrun
);

  // state | meaning
  // IDLE  | no unacknowledged record, valid=0
  // FULL  | record held for the consumer, valid=1
  typedef enum logic {IDLE, FULL} state_t;

  localparam logic [2:0]      ARM_DONE = 3'(SYNC_STAGES + 1);
  localparam logic [TS_W-1:0] TS_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev;
  logic [2:0]             arm_cnt;
  logic                   armed;
  logic                   event_det;
  logic [TS_W-1:0]        ts_cnt;
  logic [TS_W-1:0]        ts_inc;
  state_t                 state, state_nxt;
  logic                   overrun_nxt;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt == ARM_DONE);
  assign event_det = armed & (synced ^ prev);
  assign ts_inc    = (ts_cnt == TS_MAX) ? TS_MAX : ts_cnt + 1'b1;
  assign valid     = (state == FULL);

  // prev keeps following the synchronizer during arming so a static high line is absorbed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev    <= 1'b0;
      arm_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      prev   <= synced;
      if (!armed)
        arm_cnt <= arm_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt      <= '0;
      interval    <= '0;
      event_count <= '0;
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= event_det;
      if (event_det) begin
        ts_cnt      <= '0;
        interval    <= ts_inc;
        event_count <= event_count + 1'b1;
      end else begin
        ts_cnt <= ts_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= overrun_nxt;
    end
  end

  // ack wins over a coincident event, so the new record is accepted without overrun
  always_comb begin
    state_nxt   = state;
    overrun_nxt = overrun;
    case (state)
      IDLE: begin
        if (event_det)
          state_nxt = FULL;
      end
      FULL: begin
        if (ack)
          overrun_nxt = 1'b0;
        else if (event_det)
          overrun_nxt = 1'b1;
        if (ack && !event_det)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Bench for toggle_rx: directed scenarios plus randomized toggles/acks, every cycle
// compared against an event-level reference model.
module tb_toggle_rx;
  localparam int SYNC  = 2;
  localparam int CNT_W = 8;
  localparam int TS_W  = 16;
  localparam int TS_MAX = (1 << TS_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             toggle_in = 1'b1;
  logic             ack = 1'b0;
  logic             event_pulse;
  logic             valid;
  logic [TS_W-1:0]  interval;
  logic [CNT_W-1:0] event_count;
  logic             overrun;

  int total = 0;
  int bad   = 0;

  toggle_rx #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .toggle_in(toggle_in), .ack(ack),
    .event_pulse(event_pulse), .valid(valid), .interval(interval),
    .event_count(event_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a level change seen at edge k is an event at edge k+SYNC;
  // events falling inside the arming window after reset are dropped.
  int cyc, last_ev, m_int, m_cnt;
  logic m_level, m_pulse, m_valid, m_ovr, seen_pulse;
  int sched[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; last_ev = 0; m_int = 0; m_cnt = 0;
      m_level = toggle_in; m_pulse = 0; m_valid = 0; m_ovr = 0;
      sched.delete();
    end else begin
      logic ev;
      cyc++;
      ev = (sched.size() > 0 && sched[0] == cyc);
      if (ev) void'(sched.pop_front());
      if (toggle_in != m_level) begin
        m_level = toggle_in;
        if (cyc + SYNC > SYNC + 1) sched.push_back(cyc + SYNC);
      end
      m_pulse = ev;
      if (ev) begin
        m_int   = (cyc - last_ev > TS_MAX) ? TS_MAX : cyc - last_ev;
        last_ev = cyc;
        m_cnt   = (m_cnt + 1) % (1 << CNT_W);
      end
      if (m_valid && ack) begin
        m_ovr = 0;
        if (!ev) m_valid = 0;
      end else if (ev) begin
        if (m_valid) m_ovr = 1;
        m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("pulse",    int'(event_pulse), int'(m_pulse));
    chk("valid",    int'(valid),       int'(m_valid));
    chk("interval", int'(interval),    m_int);
    chk("count",    int'(event_count), m_cnt);
    chk("overrun",  int'(overrun),     int'(m_ovr));
    if (event_pulse) seen_pulse = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edge_n();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic flip();
    toggle_in = ~toggle_in;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    seen_pulse = 1'b0;
    // reset release with the line already high: no event may appear
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_count", int'(event_count), 0);
    reset = 1'b0;
    seen_pulse = 1'b0;
    tick(20);
    @(negedge clk);
    chk("static_no_evt", int'(seen_pulse), 0);
    chk("static_count",  int'(event_count), 0);
    chk("static_valid",  int'(valid), 0);

    // latency: change set up before edge 10 -> pulse after edge 12 only
    toggle_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick(9);
    flip();
    edge_n(); chk("lat_e10", int'(event_pulse), 0);
    edge_n(); chk("lat_e11", int'(event_pulse), 0);
    edge_n(); chk("lat_e12", int'(event_pulse), 1);
    chk("lat_valid", int'(valid), 1);
    chk("lat_count", int'(event_count), 1);
    edge_n(); chk("lat_e13", int'(event_pulse), 0);

    // periodic toggles 25 cycles apart, each record acknowledged
    ack_pulse();
    for (int i = 0; i < 4; i++) begin
      flip();
      tick(4);
      if (i > 0) chk("int25", int'(interval), 25);
      chk("per_ovr", int'(overrun), 0);
      ack_pulse();
      tick(20);
    end

    // two events 5 apart without ack -> overrun, cleared by ack
    flip(); tick(5);
    flip(); tick(5);
    chk("ovr_valid", int'(valid), 1);
    chk("ovr_int",   int'(interval), 5);
    chk("ovr_set",   int'(overrun), 1);
    ack_pulse();
    chk("ack_valid", int'(valid), 0);
    chk("ack_ovr",   int'(overrun), 0);

    // event and ack on the same edge
    flip(); tick(7);
    flip(); tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("co_pulse", int'(event_pulse), 1);
    chk("co_valid", int'(valid), 1);
    chk("co_int",   int'(interval), 7);
    chk("co_ovr",   int'(overrun), 0);

    // asynchronous reset mid-record
    flip(); tick(4);
    chk("pre_rst_valid", int'(valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_int",   int'(interval), 0);
    chk("arst_count", int'(event_count), 0);
    chk("arst_ovr",   int'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    tick(5);

    // 256 random-spaced events with random acks -> count wraps
    for (int i = 0; i < 256; i++) begin
      flip();
      repeat ($urandom_range(1, 8)) begin
        ack = 1'($urandom_range(0, 1));
        tick(1);
      end
    end
    ack = 1'b0;
    tick(6);
    chk("wrap_count", int'(event_count), 0);

    // long silence saturates the interval
    ack_pulse();
    flip(); tick(70000);
    flip(); tick(5);
    chk("sat_int", int'(interval), TS_MAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on toggle_in (legal values 2..4).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the width of the event counter.
REQ-003 The module SHALL have parameter TS_W, default 16, meaning the width of the interval counter and the interval output.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port toggle_in, input, 1 bit: the toggle-encoded event line; it is asynchronous to clk, and each level change is one event.
REQ-007 The module SHALL have port ack, input, 1 bit: the consumer's acknowledge of the current record.
REQ-008 The module SHALL have port event_pulse, output, 1 bit: a one-cycle strobe per decoded event.
REQ-009 The module SHALL have port valid, output, 1 bit: an unacknowledged record is present.
REQ-010 The module SHALL have port interval, output, TS_W bits: the clk cycles between the two most recent events.
REQ-011 The module SHALL have port event_count, output, CNT_W bits: the total events decoded, modulo 2^CNT_W.
REQ-012 The module SHALL have port overrun, output, 1 bit: sticky; an event arrived while valid was high and was not acknowledged.

Function
REQ-013 toggle_in SHALL pass through a SYNC_STAGES-deep flop chain before any use; no other logic samples toggle_in directly.
REQ-014 A prev register SHALL hold the previous synchronized sample; an event SHALL be detected when the synchronized sample differs from prev, with prev updated every cycle.
REQ-015 Latency SHALL be as follows: a change on toggle_in that is set up before edge N SHALL assert event_pulse after edge N+SYNC_STAGES, for exactly one cycle.
REQ-016 Arming: event detection SHALL be suppressed for the first SYNC_STAGES+1 edges after reset deasserts, while prev still tracks the synchronizer, so a static toggle_in=1 at reset release yields no event.
REQ-017 The interval counter SHALL increment every cycle and SHALL saturate at 2^TS_W-1, never wrapping.
REQ-018 In an event cycle, the interval register SHALL load the counter value plus 1 (saturated) and the counter SHALL reload 0, so events N cycles apart give interval=N.
REQ-019 event_count SHALL increment by 1 per event and SHALL wrap from 2^CNT_W-1 to 0.
REQ-020 The handshake SHALL be a two-state machine, IDLE (valid=0) and FULL (valid=1).
REQ-021 In IDLE, an event SHALL move the machine to FULL, with valid rising at the same edge as event_pulse.
REQ-022 In FULL, ack=1 with no event SHALL return the machine to IDLE, and ack SHALL be ignored in IDLE.
REQ-023 In FULL, an event together with ack=1 SHALL keep the machine in FULL with the new interval, and SHALL NOT set overrun.
REQ-024 In FULL, an event with ack=0 SHALL keep the machine in FULL, overwrite interval with the newest value, and set overrun.
REQ-025 overrun SHALL clear on any cycle in which ack=1 while in FULL; if an overrun-causing event and an ack coincide, the ack SHALL take priority and the event SHALL be treated as in REQ-023.
REQ-026 Between events, interval and event_count SHALL remain stable.

Reset
REQ-027 While reset=1, all synchronizer flops, prev, the arming counter, the interval counter, interval, event_count, valid, event_pulse and overrun SHALL be 0, and the state SHALL be IDLE.
REQ-028 Reset asserted mid-operation SHALL clear all of the above immediately, without waiting for a clk edge, and SHALL discard any pending record.

Verification
REQ-029 The bench SHALL cover: reset release with toggle_in held at 1, then 20 idle cycles -> event_pulse never asserted, event_count=0, valid=0.
REQ-030 The bench SHALL cover: toggle_in 0->1 before edge 10 -> event_pulse high only after edge 12 (SYNC_STAGES=2), valid=1, event_count=1.
REQ-031 The bench SHALL cover: toggles 25 cycles apart with ack pulsed after each -> interval=25 on each record, overrun=0.
REQ-032 The bench SHALL cover: two toggles 5 cycles apart with no ack -> valid=1, interval=5, overrun=1; then ack -> valid=0, overrun=0.
REQ-033 The bench SHALL cover: an event and an ack in the same cycle -> valid stays 1, interval updated, overrun=0.
REQ-034 The bench SHALL cover: 256 events (CNT_W=8) -> event_count wraps to 0; and no events for 70000 cycles -> next interval=65535.
